// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an asynchronous PWM line and converts them to a
// rounded duty percentage with a 7-step restoring divider; flags a stuck line.
//
// state   | meaning
// IDLE    | waiting for the first rise after reset or stuck; partial period discarded
// MEASURE | counting a full period; the next rise captures it
// DIVIDE  | (H*100 + P/2) / P, one quotient bit per cycle, k = 6 down to 0
module pwm_duty_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [6:0]       duty_pct,
    output logic             stuck,
    output logic             busy
);
    localparam int RW = CNT_W + 8;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_PRE = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DIVIDE  = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic [CNT_W-1:0]       per_ctr_q, per_ctr_d;
    logic [CNT_W-1:0]       hi_ctr_q, hi_ctr_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       div_p_q, div_p_d;
    logic [CNT_W-1:0]       div_h_q, div_h_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [6:0]             quo_q, quo_d;
    logic [2:0]             step_q, step_d;
    logic                   meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic [6:0]             duty_q, duty_d;
    logic                   stuck_q, stuck_d;

    logic          s;
    logic          rise;
    logic          timeout_hit;
    logic [RW-1:0] p_shift;
    logic [RW-1:0] rem_step;
    logic [6:0]    quo_step;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    // A rise in the same cycle wins over the timeout; DIVIDE never times out.
    assign timeout_hit = ~rise && (per_ctr_q == TO_PRE) && (state_q != ST_DIVIDE);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_d_d  = s;
        if (rise) begin
            per_ctr_d = CNT_W'(1);
            hi_ctr_d  = CNT_W'(1);
        end else begin
            per_ctr_d = (per_ctr_q >= TO_VAL) ? TO_VAL : per_ctr_q + CNT_W'(1);
            hi_ctr_d  = (s && hi_ctr_q < TO_VAL) ? hi_ctr_q + CNT_W'(1) : hi_ctr_q;
        end
    end

    always_comb begin
        p_shift  = RW'(div_p_q) << step_q;
        rem_step = rem_q;
        quo_step = quo_q;
        if (rem_q >= p_shift) begin
            rem_step = rem_q - p_shift;
            quo_step = quo_q | (7'd1 << step_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        div_p_d      = div_p_q;
        div_h_d      = div_h_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        step_d       = step_q;
        meas_valid_d = 1'b0;
        period_d     = period_q;
        high_d       = high_q;
        duty_d       = duty_q;
        stuck_d      = stuck_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (rise) begin
                    div_p_d = per_ctr_q;
                    div_h_d = hi_ctr_q;
                    rem_d   = RW'(hi_ctr_q) * RW'(100) + RW'(per_ctr_q >> 1);
                    quo_d   = 7'd0;
                    step_d  = 3'd6;
                    state_d = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (step_q == 3'd0) begin
                    period_d     = div_p_q;
                    high_d       = div_h_q;
                    duty_d       = quo_step;
                    stuck_d      = 1'b0;
                    meas_valid_d = 1'b1;
                    state_d      = ST_MEASURE;
                end else begin
                    step_d = step_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_hit) begin
            stuck_d      = 1'b1;
            duty_d       = s ? 7'd100 : 7'd0;
            period_d     = '0;
            high_d       = '0;
            meas_valid_d = 1'b1;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            s_d_q        <= 1'b0;
            per_ctr_q    <= '0;
            hi_ctr_q     <= '0;
            state_q      <= ST_IDLE;
            div_p_q      <= '0;
            div_h_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            meas_valid_q <= 1'b0;
            period_q     <= '0;
            high_q       <= '0;
            duty_q       <= '0;
            stuck_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            s_d_q        <= s_d_d;
            per_ctr_q    <= per_ctr_d;
            hi_ctr_q     <= hi_ctr_d;
            state_q      <= state_d;
            div_p_q      <= div_p_d;
            div_h_q      <= div_h_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            step_q       <= step_d;
            meas_valid_q <= meas_valid_d;
            period_q     <= period_d;
            high_q       <= high_d;
            duty_q       <= duty_d;
            stuck_q      <= stuck_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign duty_pct   = duty_q;
    assign stuck      = stuck_q;
    assign busy       = (state_q == ST_DIVIDE);
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: pin-level event model checked every cycle,
// plus literal expectations at the end of each stimulus phase.
module tb_pwm_duty_meter;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 250;
    localparam int SYNC_STAGES = 2;

    logic             clk;
    logic             rst;
    logic             pwm_in;
    logic             meas_valid;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [6:0]       duty_pct;
    logic             stuck;
    logic             busy;

    pwm_duty_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .meas_valid(meas_valid),
        .period_cnt(period_cnt),
        .high_cnt  (high_cnt),
        .duty_pct  (duty_pct),
        .stuck     (stuck),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int at;
        int per;
        int hi;
        int duty;
        bit stk;
    } ev_t;

    ev_t evq[$];

    // Model state, in terms of pin samples taken at each clock edge.
    bit m_prev;
    bit m_armed;
    bit m_acc_vld;
    int m_last_rise;
    int m_last_acc;
    int m_hi;
    int h_per, h_hi, h_duty;
    bit h_stk;

    task automatic model_step(input int n, input logic w);
        ev_t e;
        if (w && !m_prev) begin
            // A measurement is taken only outside the 7-cycle divide window.
            if (m_armed && (!m_acc_vld || n - m_last_acc >= 8)) begin
                e.at   = n + 9;
                e.per  = n - m_last_rise;
                e.hi   = m_hi;
                e.duty = (200 * e.hi + e.per) / (2 * e.per);
                e.stk  = 1'b0;
                evq.push_back(e);
                m_last_acc = n;
                m_acc_vld  = 1'b1;
            end
            m_armed     = 1'b1;
            m_last_rise = n;
            m_hi        = 1;
        end else begin
            if (w) m_hi++;
            if (n == m_last_rise + TIMEOUT - 1) begin
                e.at   = n + 2;
                e.per  = 0;
                e.hi   = 0;
                e.duty = w ? 100 : 0;
                e.stk  = 1'b1;
                evq.push_back(e);
                m_armed = 1'b0;
            end
        end
        m_prev = w;
    endtask

    initial begin
        ev_t e;
        int  ek;
        bit  e_mv;
        bit  e_busy;
        forever begin
            @(negedge clk);
            ek = cyc - 1;
            if (rst) begin
                evq.delete();
                m_prev      = 1'b0;
                m_armed     = 1'b0;
                m_acc_vld   = 1'b0;
                m_last_rise = cyc - 1;
                m_last_acc  = 0;
                m_hi        = 0;
                h_per = 0; h_hi = 0; h_duty = 0; h_stk = 1'b0;
                e_mv   = 1'b0;
                e_busy = 1'b0;
            end else begin
                e_mv = 1'b0;
                if (evq.size() > 0 && evq[0].at <= ek) begin
                    e      = evq.pop_front();
                    e_mv   = (e.at == ek);
                    h_per  = e.per;
                    h_hi   = e.hi;
                    h_duty = e.duty;
                    h_stk  = e.stk;
                end
                e_busy = m_acc_vld && ek >= m_last_acc + 2 && ek <= m_last_acc + 8;
            end
            n_chk++;
            if (meas_valid !== e_mv || busy !== e_busy || period_cnt !== CNT_W'(h_per) ||
                high_cnt !== CNT_W'(h_hi) || duty_pct !== 7'(h_duty) || stuck !== h_stk) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL cycle %0d: got mv=%0b busy=%0b per=%0d hi=%0d duty=%0d stuck=%0b, expected mv=%0b busy=%0b per=%0d hi=%0d duty=%0d stuck=%0b",
                             ek, meas_valid, busy, period_cnt, high_cnt, duty_pct, stuck,
                             e_mv, e_busy, h_per, h_hi, h_duty, h_stk);
            end
            if (!rst) model_step(ek + 1, pwm_in);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic v);
        @(posedge clk);
        #2 pwm_in = v;
    endtask

    task automatic run_pwm(input int p, input int h, input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < p; j++)
                drive_cycle(j < h);
    endtask

    initial begin
        int sweep_h[5];
        int sweep_d[5];
        sweep_h = '{6, 10, 18, 13, 4};
        sweep_d = '{30, 50, 90, 65, 20};

        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("reset_mv", int'(meas_valid), 0);
        lit("reset_period", int'(period_cnt), 0);
        lit("reset_duty", int'(duty_pct), 0);
        lit("reset_busy", int'(busy), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        run_pwm(20, 6, 5);
        @(negedge clk);
        lit("p30_period", int'(period_cnt), 20);
        lit("p30_high", int'(high_cnt), 6);
        lit("p30_duty", int'(duty_pct), 30);

        for (int i = 0; i < 5; i++) begin
            run_pwm(20, sweep_h[i], 7);
            @(negedge clk);
            lit($sformatf("sweep%0d_duty", i), int'(duty_pct), sweep_d[i]);
            lit($sformatf("sweep%0d_stuck", i), int'(stuck), 0);
        end

        run_pwm(30, 10, 3);
        @(negedge clk);
        lit("round_10_30", int'(duty_pct), 33);
        run_pwm(200, 1, 3);
        @(negedge clk);
        lit("round_1_200", int'(duty_pct), 1);
        run_pwm(200, 199, 3);
        @(negedge clk);
        lit("round_199_200", int'(duty_pct), 100);

        run_pwm(20, 6, 3);
        repeat (300) drive_cycle(1'b1);
        @(negedge clk);
        lit("stuck1_flag", int'(stuck), 1);
        lit("stuck1_duty", int'(duty_pct), 100);
        lit("stuck1_period", int'(period_cnt), 0);
        lit("stuck1_high", int'(high_cnt), 0);
        drive_cycle(1'b0);
        run_pwm(20, 8, 4);
        @(negedge clk);
        lit("p40_duty", int'(duty_pct), 40);
        lit("p40_stuck", int'(stuck), 0);
        repeat (300) drive_cycle(1'b0);
        @(negedge clk);
        lit("stuck0_flag", int'(stuck), 1);
        lit("stuck0_duty", int'(duty_pct), 0);

        run_pwm(6, 3, 10);
        run_pwm(9, 3, 5);
        @(negedge clk);
        lit("p9_duty", int'(duty_pct), 33);
        lit("p9_period", int'(period_cnt), 9);
        lit("p9_stuck", int'(stuck), 0);

        run_pwm(20, 6, 3);
        drive_cycle(1'b1);
        repeat (4) drive_cycle(1'b1);
        rst = 1'b1;
        @(negedge clk);
        lit("midrst_mv", int'(meas_valid), 0);
        lit("midrst_duty", int'(duty_pct), 0);
        lit("midrst_period", int'(period_cnt), 0);
        lit("midrst_busy", int'(busy), 0);
        drive_cycle(1'b1);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        rst = 1'b0;
        repeat (11) drive_cycle(1'b0);
        run_pwm(20, 6, 4);
        @(negedge clk);
        lit("postrst_duty", int'(duty_pct), 30);
        lit("postrst_high", int'(high_cnt), 6);

        repeat (12) drive_cycle(1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
